// File: rtl/conv_spad_ctrl.sv
// Sequencer for one PE's ifmap scratchpad: fills the shift-register FIFO to the
// filter length, then walks every stride-1 window issuing read selects and MAC strobes.
module conv_spad_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_filter_len,
  input  logic [LEN_WIDTH-1:0]  cfg_row_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fifo_load_enable,
  output logic [DATA_WIDTH-1:0] fifo_value_in,
  output logic [ADDR_WIDTH-1:0] fifo_reg_select,
  output logic [ADDR_WIDTH-1:0] weight_select,
  output logic                  mac_en,
  output logic                  mac_first,
  output logic                  mac_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMPUTE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [SW-1:0]          s_len;
  logic [SW-1:0]          fill_cnt;
  logic [LEN_WIDTH-1:0]   w_len;
  logic [LEN_WIDTH-1:0]   consumed;
  logic [ADDR_WIDTH-1:0]  tap;
  logic [SW-1:0]          s_m1;
  logic                   handshake;
  logic                   cfg_bad;

  assign in_ready         = (state == ST_FILL) || (state == ST_SHIFT);
  assign handshake        = in_valid & in_ready;
  assign fifo_load_enable = handshake;
  assign fifo_value_in    = in_data;
  assign busy             = (state != ST_IDLE);
  assign weight_select    = tap;
  assign s_m1             = s_len - SW'(1);

  assign cfg_bad = (cfg_filter_len == '0) ||
                   (cfg_filter_len > SW'(DEPTH)) ||
                   (cfg_row_len < LEN_WIDTH'(cfg_filter_len));

  // Window taps run oldest-first: memory[0] holds the newest sample, so the
  // read select counts down from S-1 while the weight index counts up from 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state           <= ST_IDLE;
      s_len           <= '0;
      w_len           <= '0;
      fill_cnt        <= '0;
      consumed        <= '0;
      tap             <= '0;
      fifo_reg_select <= '0;
      mac_en          <= 1'b0;
      mac_first       <= 1'b0;
      mac_last        <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge values of the state and counters.
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              s_len    <= cfg_filter_len;
              w_len    <= cfg_row_len;
              fill_cnt <= '0;
              consumed <= '0;
              tap      <= '0;
              state    <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          if (handshake) begin
            fill_cnt <= fill_cnt + SW'(1);
            consumed <= consumed + LEN_WIDTH'(1);
            if (fill_cnt == s_m1) begin
              state           <= ST_COMPUTE;
              tap             <= '0;
              fifo_reg_select <= s_m1[ADDR_WIDTH-1:0];
              mac_en          <= 1'b1;
              mac_first       <= 1'b1;
              mac_last        <= (s_len == SW'(1));
            end
          end
        end

        ST_COMPUTE: begin
          if ({1'b0, tap} == s_m1) begin
            tap             <= '0;
            fifo_reg_select <= '0;
            mac_en          <= 1'b0;
            mac_first       <= 1'b0;
            mac_last        <= 1'b0;
            if (consumed == w_len) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end else begin
            tap             <= tap + ADDR_WIDTH'(1);
            fifo_reg_select <= fifo_reg_select - ADDR_WIDTH'(1);
            mac_first       <= 1'b0;
            mac_last        <= (({1'b0, tap} + SW'(1)) == s_m1);
          end
        end

        ST_SHIFT: begin
          if (handshake) begin
            consumed        <= consumed + LEN_WIDTH'(1);
            state           <= ST_COMPUTE;
            tap             <= '0;
            fifo_reg_select <= s_m1[ADDR_WIDTH-1:0];
            mac_en          <= 1'b1;
            mac_first       <= 1'b1;
            mac_last        <= (s_len == SW'(1));
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_spad_ctrl.md
Name: conv_spad_ctrl

Overview:
- Sequencer for one PE's ifmap scratchpad, the shift-register FIFO with arbitrary read select.
- Accepts an ifmap row over a valid/ready stream and fills the FIFO to the filter length S.
- For each 1-D sliding window (stride 1) it issues S read selects plus matching weight indices and MAC strobes, then shifts in the next sample.
- Sits between the PE's input network port and the FIFO/MAC datapath.

Parameters:
- ADDR_WIDTH, 3, FIFO address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, ifmap sample width.
- LEN_WIDTH, 16, width of the row-length count.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  begin a row; sampled only in IDLE.
- cfg_filter_len  input  ADDR_WIDTH+1  S, legal 1..DEPTH; latched on accepted start.
- cfg_row_len  input  LEN_WIDTH  W, ifmap samples in row, legal W>=S; latched on start.
- in_valid  input  1  ifmap sample valid.
- in_data  input  DATA_WIDTH  ifmap sample (signed).
- in_ready  output  1  controller accepts sample this cycle.
- fifo_load_enable  output  1  FIFO push strobe.
- fifo_value_in  output  DATA_WIDTH  FIFO push data.
- fifo_reg_select  output  ADDR_WIDTH  FIFO read address.
- weight_select  output  ADDR_WIDTH  filter tap index k.
- mac_en  output  1  accumulate product this cycle.
- mac_first  output  1  first tap of a window (clear accumulator).
- mac_last  output  1  last tap of a window (psum complete).
- busy  output  1  not in IDLE.
- done  output  1  one-cycle pulse, row complete.
- cfg_err  output  1  one-cycle pulse, illegal config at start.

Behaviour:
- States: IDLE, FILL, COMPUTE, SHIFT, DONE. Registers: state, S, W, fill_cnt, consumed (LEN_WIDTH), tap k.
- Reset (async, rstb low): state=IDLE; all counters 0; every output 0. Reset mid-row abandons the row; no done is issued.
- in_ready = (state==FILL || state==SHIFT), combinational from state.
- fifo_load_enable = in_valid & in_ready; fifo_value_in = in_data (passthrough). Handshake completes on a cycle with both high. in_valid in other states is ignored, never consumed.
- IDLE:
  - start with S==0, S>DEPTH, or W<S: cfg_err=1 for the next cycle, stay IDLE.
  - start with legal config: latch S and W, clear counters, go to FILL.
- FILL: each handshake increments fill_cnt and consumed. On the handshake with fill_cnt==S-1, go to COMPUTE with k=0.
- COMPUTE: one tap per cycle.
  - mac_en=1; weight_select=k; fifo_reg_select=S-1-k. memory[0] is the newest sample, so tap 0 pairs with the oldest window sample.
  - mac_first=(k==0); mac_last=(k==S-1). With S=1, both are asserted in the same cycle.
  - After k==S-1: if consumed==W, go to DONE; else go to SHIFT. Otherwise k++.
- SHIFT: wait for a handshake (stall indefinitely; no mac strobes while waiting). On the handshake, consumed++ and go to COMPUTE with k=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Outside COMPUTE: mac_en, mac_first, mac_last are 0; fifo_reg_select and weight_select are 0.
- start while busy is ignored; no effect on the current row.
- Windows per row = W-S+1. With in_valid held high: FILL takes S cycles, COMPUTE S cycles per window, SHIFT 1 cycle per window after the first.
- FIFO entries above S-1 are stale and never selected.
- consumed never exceeds W; no input is accepted after the last window.

Test Plan:
- S=3, W=5, in_data=1..5, in_valid held high.
  - Windows read (1,2,3),(2,3,4),(3,4,5).
  - fifo_reg_select per window is 2,1,0; weight_select is 0,1,2.
  - 3 mac_first and 3 mac_last pulses.
  - done asserted 15 cycles after the start cycle (3 fill + 9 compute + 2 shift + DONE).
  - Exactly 5 fifo_load_enable pulses.
- Same row with in_valid low for 4 cycles in each SHIFT: in_ready stays high, mac_en stays 0 during the stall, identical read sequence, done delayed by 8 cycles.
- Config errors, each -> cfg_err single pulse, busy stays 0, no in_ready:
  - cfg_filter_len=0.
  - cfg_filter_len=9 with DEPTH=8.
  - S=4, W=3.
- S=8, W=8: one window; fifo_reg_select 7..0; single mac_last; no SHIFT state visited.
- S=1, W=4: four windows, each one cycle with mac_first=mac_last=1 and fifo_reg_select=0.
- rstb low during the 2nd window's k=1, then start again.
  - Immediately on reset: all outputs 0, no done pulse.
  - After the restart: a full clean row is processed.
- start pulsed in the middle of COMPUTE: ignored, row completes unchanged.
